// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions.
//   - funct3 encodings for the load/store width field
//   - state encoding of the data-memory responder FSM
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// RV32I byte-lane steering for one load or store (purely combinational).
// Ports:
//   funct3 - load/store width code
//   lane   - addr[1:0], byte offset inside the word
//   rword  - storage word at the addressed index
//   wdata  - store data, right-aligned
//   write  - 1 = store, 0 = load
//   be     - byte enables for the store
//   wword  - store data replicated onto the addressed lanes
//   rdata  - sign/zero-extended load result
//   fault  - misaligned access or funct3 not legal for this direction
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic        write,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        fault
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    be    = 4'b0000;
    wword = wdata;
    rdata = '0;
    fault = 1'b0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        rdata = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        fault = lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = {{16{rhalf[15]}}, rhalf};
      end
      F3_W: begin
        fault = (lane != 2'b00);
        be    = 4'b1111;
        rdata = rword;
      end
      // Unsigned widths exist only for loads.
      F3_BU: begin
        fault = write;
        rdata = {24'b0, rbyte};
      end
      F3_HU: begin
        fault = write | lane[0];
        rdata = {16'b0, rhalf};
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-stage load/store interface.
// One request is accepted at a time; after WAIT_CYCLES wait states the
// access is performed and the result is offered on the response channel
// until the requester takes it.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   req_valid/req_ready  - request handshake (ready only while idle)
//   req_write            - 1 = store, 0 = load
//   req_funct3           - RV32I funct3 of the access
//   req_addr, req_wdata  - byte address, right-aligned store data
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata            - extended load data; 0 for stores and faults
//   rsp_err              - misaligned, out-of-range or illegal access
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDRESS_WIDTH-3:0] DEPTH_LIM = (ADDRESS_WIDTH-2)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]         CNT_INIT  = CNT_W'(WAIT_CYCLES);

  state_e                   state, state_nxt;
  logic [CNT_W-1:0]         count;
  logic                     lat_write;
  logic [2:0]               lat_funct3;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0]    lat_wdata;
  logic [DATA_WIDTH-1:0]    mem [DEPTH_WORDS];

  logic                     accept, do_access, range_err, fault, err;
  logic                     acc_write;
  logic [2:0]               acc_funct3;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0]    acc_wdata, rword, wword, ld_data;
  logic [IDX_W-1:0]         idx;
  logic [3:0]               be;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;

  // With zero wait states the access happens on the accept edge, so the
  // live request is used; otherwise the latched copy is.
  assign acc_write  = (state == IDLE) ? req_write  : lat_write;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
  assign acc_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

  // rst is folded in so nothing reaches storage while reset is held.
  assign do_access = rst & ((accept & (WAIT_CYCLES == 0)) |
                            ((state == WAIT) & (count == CNT_W'(1))));

  assign idx       = acc_addr[IDX_W+1:2];
  assign rword     = mem[idx];
  assign range_err = (acc_addr[ADDRESS_WIDTH-1:2] >= DEPTH_LIM);
  assign err       = range_err | fault;

  lsu_lane_align u_align (
    .funct3 (acc_funct3),
    .lane   (acc_addr[1:0]),
    .rword  (rword),
    .wdata  (acc_wdata),
    .write  (acc_write),
    .be     (be),
    .wword  (wword),
    .rdata  (ld_data),
    .fault  (fault)
  );

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (count == CNT_W'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      lat_write  <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        lat_write  <= req_write;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        count      <= CNT_INIT;
      end else if (state == WAIT) begin
        count <= count - CNT_W'(1);
      end
      if (do_access) begin
        rsp_err   <= err;
        rsp_rdata <= (err | acc_write) ? '0 : ld_data;
      end
    end
  end

  // NOTE: storage has no reset; contents survive rst and only a committed,
  // fault-free store changes them.
  always_ff @(posedge clk) begin
    if (do_access && acc_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import riscv_pkg::*;

  typedef struct {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_a = 1'b0, req_valid_z = 1'b0;
  logic        req_ready_a, req_ready_z;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid_a, rsp_valid_z;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata_a, rsp_rdata_z;
  logic        rsp_err_a, rsp_err_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a)
  );

  dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full request/response with rsp_ready held high. z selects the
  // zero-wait instance. lat counts edges from accept to rsp_valid.
  task automatic transact(input bit z, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    if (z) req_valid_z = 1'b1; else req_valid_a = 1'b1;
    n = 0;
    while (!(z ? req_ready_z : req_ready_a) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept ready", {31'b0, (z ? req_ready_z : req_ready_a)}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_a = 1'b0; req_valid_z = 1'b0;
    // Scramble the request bus: the DUT must use its latched copy.
    req_write = ~w; req_addr = a ^ 32'h4; req_wdata = ~d; req_funct3 = F3_W;
    lat = 0;
    @(negedge clk);
    while (!(z ? rsp_valid_z : rsp_valid_a) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = z ? rsp_rdata_z : rsp_rdata_a;
    er = z ? rsp_err_z : rsp_err_a;
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs[22];
  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    vecs[0]  = '{1'b1, F3_W,  32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, F3_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, F3_B,  32'h0000_0013, 32'h0,         32'hFFFF_FFDE, 1'b0};
    vecs[4]  = '{1'b0, F3_BU, 32'h0000_0013, 32'h0,         32'h0000_00DE, 1'b0};
    vecs[5]  = '{1'b0, F3_H,  32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 1'b0};
    vecs[6]  = '{1'b0, F3_HU, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 1'b0};
    vecs[7]  = '{1'b1, F3_B,  32'h0000_0011, 32'hAAAA_AA55, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[9]  = '{1'b0, F3_B,  32'h0000_0011, 32'h0,         32'h0000_0055, 1'b0};
    vecs[10] = '{1'b0, F3_W,  32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, F3_H,  32'h0000_0011, 32'h0000_1234, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b1, F3_W,  32'h0000_1000, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, F3_W,  32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 3'd3,  32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, F3_BU, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[17] = '{1'b0, F3_W,  32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
    vecs[18] = '{1'b1, F3_H,  32'h0000_0012, 32'h0000_A5C3, 32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, F3_W,  32'h0000_0010, 32'h0,         32'hA5C3_55EF, 1'b0};
    vecs[20] = '{1'b0, F3_H,  32'h0000_0012, 32'h0,         32'hFFFF_A5C3, 1'b0};
    vecs[21] = '{1'b1, F3_W,  32'h0000_0020, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};

    // Reset state, sampled while reset is held.
    repeat (2) @(negedge clk);
    check("reset req_ready", {31'b0, req_ready_a}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
    check("reset rsp_rdata", rsp_rdata_a, 32'd0);
    check("reset rsp_err",   {31'b0, rsp_err_a}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      transact(1'b0, vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d latency", i), lat, 32'd2);
    end

    // Backpressure: response held, new request ignored.
    rsp_ready = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_valid_a = 1'b1;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp valid c%0d", i), {31'b0, rsp_valid_a}, 32'd1);
      check($sformatf("bp rdata c%0d", i), rsp_rdata_a, 32'hA5C3_55EF);
      check($sformatf("bp req_ready c%0d", i), {31'b0, req_ready_a}, 32'd0);
      req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0;
      req_valid_a = 1'b1;
    end
    @(negedge clk);
    req_valid_a = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", {31'b0, rsp_valid_a}, 32'd0);
    check("bp release ready", {31'b0, req_ready_a}, 32'd1);
    transact(1'b0, 1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
    check("bp store ignored", rd, 32'hA5C3_55EF);

    // Reset while a store is still waiting.
    @(negedge clk);
    req_write = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_valid_a = 1'b1;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst req_ready", {31'b0, req_ready_a}, 32'd1);
    check("rst rsp_valid after", {31'b0, rsp_valid_a}, 32'd0);
    transact(1'b0, 1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
    check("rst store dropped", rd, 32'hA5A5_A5A5);

    // Zero wait states.
    transact(1'b1, 1'b1, F3_W, 32'h8, 32'h0BAD_F00D, rd, er, lat);
    check("w0 store latency", lat, 32'd0);
    check("w0 store err", {31'b0, er}, 32'd0);
    transact(1'b1, 1'b0, F3_W, 32'h8, 32'h0, rd, er, lat);
    check("w0 load latency", lat, 32'd0);
    check("w0 load rdata", rd, 32'h0BAD_F00D);
    transact(1'b1, 1'b0, F3_B, 32'hB, 32'h0, rd, er, lat);
    check("w0 lb rdata", rd, 32'h0000_000B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
